// File: rtl/playback_if.sv
// SRAM read bus between the playback engine and the async SRAM.
// Signal names match the board-level SRAM pins.
interface playback_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ;
  logic              SRAM_CE;
  logic              SRAM_OE;
  logic              SRAM_WE;
  logic              SRAM_LB;
  logic              SRAM_UB;

  modport master (
    output SRAM_ADDR,
    output SRAM_CE,
    output SRAM_OE,
    output SRAM_WE,
    output SRAM_LB,
    output SRAM_UB,
    input  SRAM_DQ
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_CE,
    input  SRAM_OE,
    input  SRAM_WE,
    input  SRAM_LB,
    input  SRAM_UB,
    output SRAM_DQ
  );
endinterface

// File: rtl/playback.sv
// SRAM-to-WM8731 I2S playback engine (codec is clock master).
// Even addresses go to the left slot, odd addresses to the right.
module playback #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  playback_if.master        sram,
  input  logic              play_btn,
  input  logic              pause_btn,
  input  logic              stop_btn,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              playing,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] bsync_q, lsync_q;
  logic                   bprev_q, lprev_q;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dac_q, dac_d;
  logic              done_q, done_d;
  logic              loaded_q, loaded_d;
  logic              last_q, last_d;
  logic              preq_q, preq_d;

  logic bclk_s, lrck_s;
  logic bfall, ledge;

  assign bclk_s = bsync_q[SYNC_STAGES-1];
  assign lrck_s = lsync_q[SYNC_STAGES-1];
  assign bfall  = bprev_q & ~bclk_s;
  assign ledge  = lprev_q ^ lrck_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bsync_q <= '0;
      lsync_q <= '0;
      bprev_q <= 1'b0;
      lprev_q <= 1'b0;
    end else begin
      bsync_q <= {bsync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lsync_q <= {lsync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
      bprev_q <= bclk_s;
      lprev_q <= lrck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      dac_q    <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      last_q   <= 1'b0;
      preq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
      last_q   <= last_d;
      preq_q   <= preq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    last_d   = last_q;
    preq_d   = preq_q;

    if (!stop_btn) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      shift_d  = '0;
      cnt_d    = '0;
      dac_d    = 1'b0;
      loaded_d = 1'b0;
      last_d   = 1'b0;
      preq_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pause_btn && !play_btn && end_addr != '0) begin
            state_d  = S_PLAY;
            loaded_d = 1'b0;
            last_d   = 1'b0;
            preq_d   = 1'b0;
          end
        end
        S_PLAY: begin
          if (!pause_btn) preq_d = 1'b1;
          if (ledge) begin
            cnt_d    = '0;
            dac_d    = 1'b0;
            loaded_d = 1'b0;
            if (last_q) begin
              state_d = S_IDLE;
              addr_d  = '0;
              shift_d = '0;
              done_d  = 1'b1;
              last_d  = 1'b0;
              preq_d  = 1'b0;
            end else if (preq_q) begin
              state_d = S_PAUSE;
              shift_d = '0;
              preq_d  = 1'b0;
            end else if (addr_q[0] == lrck_s && addr_q <= end_addr) begin
              // end flag taken on load so a wrap to 0 cannot re-arm
              shift_d  = sram.SRAM_DQ;
              addr_d   = addr_q + 1'b1;
              loaded_d = 1'b1;
              last_d   = (addr_q == end_addr);
            end
          end else if (bfall && loaded_q) begin
            if (cnt_q < CNT_MAX) begin
              dac_d   = shift_q[DATA_W-1];
              shift_d = shift_q << 1;
              cnt_d   = cnt_q + 1'b1;
            end else begin
              dac_d = 1'b0;
            end
          end
        end
        S_PAUSE: begin
          dac_d = 1'b0;
          if (pause_btn && !play_btn) begin
            state_d  = S_PLAY;
            loaded_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign playing        = (state_q == S_PLAY);
  assign done           = done_q;
  assign AUD_DACDAT     = dac_q;
  assign sram.SRAM_ADDR = addr_q;
  assign sram.SRAM_CE   = (state_q == S_IDLE);
  assign sram.SRAM_OE   = (state_q == S_IDLE);
  assign sram.SRAM_LB   = (state_q == S_IDLE);
  assign sram.SRAM_UB   = (state_q == S_IDLE);
  assign sram.SRAM_WE   = 1'b1;

endmodule

// File: tb/tb_playback.sv
// Directed bench for playback: drives codec clocks, models SRAM,
// and checks serial output words and control behaviour.
module tb_playback;

  logic        clk;
  logic        reset;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        play_btn;
  logic        pause_btn;
  logic        stop_btn;
  logic [19:0] end_addr;
  logic        playing;
  logic        done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [15:0] mem [16];
  logic [19:0] v;

  playback_if #(.ADDR_W(20), .DATA_W(16)) sif ();

  playback #(
    .ADDR_W(20),
    .DATA_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT (AUD_DACDAT),
    .sram       (sif),
    .play_btn   (play_btn),
    .pause_btn  (pause_btn),
    .stop_btn   (stop_btn),
    .end_addr   (end_addr),
    .playing    (playing),
    .done       (done)
  );

  assign sif.SRAM_DQ = mem[sif.SRAM_ADDR[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fall(output logic d);
    AUD_BCLK = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    d = AUD_DACDAT;
    AUD_BCLK = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic falls(input int n, inout logic [19:0] w);
    logic b;
    for (int i = 0; i < n; i++) begin
      fall(b);
      w = {w[18:0], b};
    end
  endtask

  task automatic slot(input logic lvl, output logic [19:0] w);
    w = '0;
    AUD_DACLRCK = lvl;
    falls(20, w);
  endtask

  task automatic press_play();
    play_btn = 1'b0;
    repeat (2) @(negedge clk);
    play_btn = 1'b1;
  endtask

  task automatic press_pause();
    pause_btn = 1'b0;
    repeat (2) @(negedge clk);
    pause_btn = 1'b1;
  endtask

  initial begin
    mem[0] = 16'hA5C3; mem[1] = 16'h0F0F;
    mem[2] = 16'h1234; mem[3] = 16'h8001;
    mem[4] = 16'hC0DE; mem[5] = 16'h7FFE;
    mem[6] = 16'h6666; mem[7] = 16'h7777;
    mem[8] = 16'hF00F;
    for (int i = 9; i < 16; i++) mem[i] = 16'h0000;

    reset = 1'b0;
    AUD_BCLK = 1'b1;
    AUD_DACLRCK = 1'b1;
    play_btn = 1'b1;
    pause_btn = 1'b1;
    stop_btn = 1'b1;
    end_addr = 20'd1;
    repeat (3) @(negedge clk);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_ce", 32'(sif.SRAM_CE), 32'd1);
    chk("rst_we", 32'(sif.SRAM_WE), 32'd1);
    chk("rst_addr", 32'(sif.SRAM_ADDR), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // T2: two-word playback, end of data
    press_play();
    chk("t2_playing", 32'(playing), 32'd1);
    chk("t2_ce", 32'(sif.SRAM_CE), 32'd0);
    chk("t2_oe", 32'(sif.SRAM_OE), 32'd0);
    chk("t2_lbub", 32'({sif.SRAM_LB, sif.SRAM_UB}), 32'd0);
    chk("t2_we", 32'(sif.SRAM_WE), 32'd1);
    slot(1'b0, v);
    chk("t2_left", 32'(v), 32'({1'b0, 16'hA5C3, 3'b000}));
    chk("t2_addr1", 32'(sif.SRAM_ADDR), 32'd1);
    slot(1'b1, v);
    chk("t2_right", 32'(v), 32'({1'b0, 16'h0F0F, 3'b000}));
    chk("t2_nodone", 32'(done_cnt), 32'd0);
    AUD_DACLRCK = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_done1", 32'(done_cnt), 32'd1);
    chk("t2_idle", 32'(playing), 32'd0);
    chk("t2_addr0", 32'(sif.SRAM_ADDR), 32'd0);
    chk("t2_ce_idle", 32'(sif.SRAM_CE), 32'd1);

    // T1: reset in the middle of a word
    end_addr = 20'd5;
    AUD_DACLRCK = 1'b1;
    repeat (6) @(negedge clk);
    press_play();
    AUD_DACLRCK = 1'b0;
    v = '0;
    falls(8, v);
    chk("t1_bits", 32'(v[7:0]), 32'h52);
    chk("t1_play", 32'(playing), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t1_idle", 32'(playing), 32'd0);
    chk("t1_dac", 32'(AUD_DACDAT), 32'd0);
    chk("t1_addr", 32'(sif.SRAM_ADDR), 32'd0);
    chk("t1_ce", 32'(sif.SRAM_CE), 32'd1);
    repeat (4) @(negedge clk);

    // T3: start on a right slot is skipped
    end_addr = 20'd20;
    press_play();
    slot(1'b1, v);
    chk("t3_skip", 32'(v), 32'd0);
    chk("t3_addr", 32'(sif.SRAM_ADDR), 32'd0);
    slot(1'b0, v);
    chk("t3_w0", 32'(v), 32'({1'b0, 16'hA5C3, 3'b000}));
    slot(1'b1, v);
    chk("t3_w1", 32'(v), 32'({1'b0, 16'h0F0F, 3'b000}));
    slot(1'b0, v);
    chk("t3_w2", 32'(v), 32'({1'b0, 16'h1234, 3'b000}));
    slot(1'b1, v);
    chk("t3_w3", 32'(v), 32'({1'b0, 16'h8001, 3'b000}));

    // T4: pause at bit 5 of word 4, resume on right slot
    AUD_DACLRCK = 1'b0;
    v = '0;
    falls(6, v);
    press_pause();
    falls(14, v);
    chk("t4_w4", 32'(v), 32'({1'b0, 16'hC0DE, 3'b000}));
    chk("t4_addr5", 32'(sif.SRAM_ADDR), 32'd5);
    slot(1'b1, v);
    chk("t4_pause_out", 32'(v), 32'd0);
    chk("t4_paused", 32'(playing), 32'd0);
    chk("t4_ce_pause", 32'(sif.SRAM_CE), 32'd0);
    chk("t4_addr_hold", 32'(sif.SRAM_ADDR), 32'd5);
    press_play();
    chk("t4_resume", 32'(playing), 32'd1);
    slot(1'b0, v);
    chk("t4_left_skip", 32'(v), 32'd0);
    slot(1'b1, v);
    chk("t4_w5", 32'(v), 32'({1'b0, 16'h7FFE, 3'b000}));
    chk("t4_addr6", 32'(sif.SRAM_ADDR), 32'd6);
    slot(1'b0, v);
    chk("t4_w6", 32'(v), 32'({1'b0, 16'h6666, 3'b000}));
    slot(1'b1, v);

    // T5: stop beats play mid-word
    AUD_DACLRCK = 1'b0;
    v = '0;
    falls(3, v);
    chk("t5_bit", 32'(v[1:0]), 32'd3);
    chk("t5_addr9", 32'(sif.SRAM_ADDR), 32'd9);
    stop_btn = 1'b0;
    play_btn = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(playing), 32'd0);
    chk("t5_addr0", 32'(sif.SRAM_ADDR), 32'd0);
    chk("t5_dac", 32'(AUD_DACDAT), 32'd0);
    chk("t5_ce", 32'(sif.SRAM_CE), 32'd1);
    stop_btn = 1'b1;
    play_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_nodone", 32'(done_cnt), 32'd1);

    // T6: empty recording never starts
    end_addr = 20'd0;
    press_play();
    repeat (4) @(negedge clk);
    chk("t6_idle", 32'(playing), 32'd0);
    chk("t6_ce", 32'(sif.SRAM_CE), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
